// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Burst read/write controller for a 16x4 memory with combinational read data.
// A request captured in IDLE starts a burst of Req_Len+1 words from Req_Addr,
// wrapping modulo 16. Reads stream out through a registered Rd_Q/Rd_Vld pair;
// writes accept one beat per cycle through a Wd_Vld/Wd_Rdy handshake.
//
// Optional feature: define MEM_ACCESS_CTRL_VERIFY_EN to follow every write
// beat with a VERIFY cycle that reads the word back and raises the sticky Err
// flag on a mismatch. Without the macro there is no VERIFY state, Err is tied
// low and write beats stream back-to-back.
module mem_access_ctrl (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Req,
    input  logic       Rw,
    input  logic [3:0] Req_Addr,
    input  logic [3:0] Req_Len,
    input  logic       Wd_Vld,
    input  logic [3:0] Wd_D,
    output logic       Wd_Rdy,
    output logic       Rd_Vld,
    output logic [3:0] Rd_Q,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic       Mem_Wr,
    output logic [3:0] Mem_Wr_D,
    output logic [3:0] Mem_Addr,
    input  logic [3:0] Mem_Rd_D
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
        ST_VERIFY,
`endif
        ST_DONE
    } state_t;

    state_t     r_state;
    logic [3:0] r_addr;
    logic [3:0] r_cnt;
    logic [3:0] r_rd_q;
    logic       r_rd_vld;
    logic       r_done;

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    logic [3:0] r_wdata;
    logic       r_err;
`endif

    logic       w_beat;
    logic       w_last;
    logic [3:0] w_addr_inc;
    logic [3:0] w_cnt_dec;

    // Word-completion helpers: last-word detect and the post-word address/count.
    assign w_last     = (r_cnt == 4'd0);
    assign w_addr_inc = r_addr + 4'd1;
    assign w_cnt_dec  = r_cnt - 4'd1;

    // A write beat is a handshake in WRITE; reset masks it so the memory is never written while Rst_n is low.
    assign w_beat = (r_state == ST_WRITE) && Wd_Vld && Rst_n;

    // Main FSM with registered read data, read-valid, done pulse and error flag.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= 4'd0;
            r_cnt    <= 4'd0;
            r_rd_q   <= 4'd0;
            r_rd_vld <= 1'b0;
            r_done   <= 1'b0;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
            r_wdata  <= 4'd0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_rd_vld <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Req) begin
                        r_addr  <= Req_Addr;
                        r_cnt   <= Req_Len;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= Rw ? ST_WRITE : ST_READ;
                    end
                end

                ST_READ: begin
                    r_rd_q   <= Mem_Rd_D;
                    r_rd_vld <= 1'b1;
                    r_addr   <= w_addr_inc;
                    r_cnt    <= w_cnt_dec;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (Wd_Vld) begin
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                        r_wdata <= Wd_D;
                        r_state <= ST_VERIFY;
`else
                        r_addr  <= w_addr_inc;
                        r_cnt   <= w_cnt_dec;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
`endif
                    end
                end

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
                ST_VERIFY: begin
                    if (Mem_Rd_D != r_wdata) begin
                        r_err <= 1'b1;
                    end
                    r_addr <= w_addr_inc;
                    r_cnt  <= w_cnt_dec;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_WRITE;
                    end
                end
`endif

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory address follows the burst pointer only while a burst is touching memory.
    always_comb begin
        Mem_Addr = 4'd0;
        case (r_state)
            ST_WRITE:  Mem_Addr = r_addr;
            ST_READ:   Mem_Addr = r_addr;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
            ST_VERIFY: Mem_Addr = r_addr;
`endif
            default:   Mem_Addr = 4'd0;
        endcase
    end

    assign Wd_Rdy   = (r_state == ST_WRITE);
    assign Mem_Wr   = w_beat;
    assign Mem_Wr_D = w_beat ? Wd_D : 4'd0;
    assign Busy     = (r_state != ST_IDLE);
    assign Done     = r_done;
    assign Rd_Vld   = r_rd_vld;
    assign Rd_Q     = r_rd_q;

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    assign Err = r_err;
`else
    assign Err = 1'b0;
`endif

endmodule
